// File: rtl/iir_post_decimator.sv
// Boxcar decimator: averages each block of `decim` samples and queues the
// results in a show-ahead FIFO drained by a valid/ready consumer.
module iir_post_decimator #(
    parameter int bitwidth   = 32,
    parameter int decim      = 4,
    parameter int fifo_depth = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_en,
    input  logic [bitwidth-1:0]           din,
    output logic [bitwidth-1:0]           dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic                          overflow
);
    localparam int SH = $clog2(decim);
    localparam int AW = bitwidth + SH;
    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;

    logic [SH-1:0]        phase;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] din_ext;
    logic signed [AW-1:0] sum;
    logic [bitwidth-1:0]  result;
    logic [bitwidth-1:0]  mem [fifo_depth];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 blk_done;
    logic                 full;
    logic                 pop;
    logic                 do_push;

    assign din_ext  = signed'({{SH{din[bitwidth-1]}}, din});
    assign sum      = acc + din_ext;
    // Taking the upper bits of the exact sum is the floor-shift, truncated.
    assign result   = sum[AW-1:SH];
    assign blk_done = in_en && (phase == SH'(decim - 1));

    assign dout_valid = (fifo_count != '0);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;
    assign full       = (fifo_count == CW'(fifo_depth));
    assign pop        = dout_valid && dout_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign do_push    = blk_done && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase      <= '0;
            acc        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (in_en) begin
                phase <= phase + 1'b1;
                acc   <= (phase == '0) ? din_ext : sum;
            end
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(do_push) - CW'(pop);
            if (blk_done && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push)
            mem[wr_ptr] <= result;
    end
endmodule

// File: tb/tb_iir_post_decimator.sv
// Randomized and directed checks of the decimator against a block-average
// reference built from sample lists and a queue.
module tb_iir_post_decimator;
    localparam int D     = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_en = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [3:0]  fifo_count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    logic [31:0] mq[$];
    int          blk[$];
    bit          movf;

    iir_post_decimator #(.bitwidth(32), .decim(D), .fifo_depth(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_en(in_en), .din(din),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] block_avg();
        longint s = 0;
        longint q;
        foreach (blk[i]) s += longint'(blk[i]);
        q = s / D;
        if ((s % D) != 0 && s < 0) q -= 1;
        return q[31:0];
    endfunction

    // One clock: apply inputs, advance the reference, settle at the falling edge.
    task automatic drive(input bit en, input logic [31:0] d, input bit rdy, input bit rst);
        bit p;
        bit f;
        logic [31:0] r;
        in_en = en; din = d; dout_ready = rdy; rst_n = !rst;
        @(posedge clk);
        if (rst) begin
            mq.delete(); blk.delete(); movf = 0;
        end else begin
            p = (mq.size() > 0) && rdy;
            f = (mq.size() == DEPTH);
            if (p) void'(mq.pop_front());
            if (en) begin
                blk.push_back(int'(d));
                if (blk.size() == D) begin
                    r = block_avg();
                    blk.delete();
                    if (!f || p) mq.push_back(r);
                    else movf = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(1, $urandom, $urandom_range(0, 1), 1);
        checks++;
        if (dout !== 32'd0 || dout_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset: got dout=%0h v=%0b cnt=%0d ovf=%0b want 0/0/0/0",
                     dout, dout_valid, fifo_count, overflow);
        end
    endtask

    task automatic test_average();
        drive(0, 0, 0, 1);
        drive(1, 4, 0, 0); drive(1, 8, 0, 0); drive(1, 12, 0, 0); drive(1, 16, 0, 0);
        checks++;
        if (dout !== 32'd10 || dout_valid !== 1'b1) begin
            failures++;
            $display("FAIL avg_first: got dout=%0d v=%0b want 10/1", dout, dout_valid);
        end
        drive(1, -1, 0, 0); drive(1, -2, 0, 0); drive(1, -3, 0, 0); drive(1, -4, 0, 0);
        checks++;
        if (fifo_count !== 4'd2 || dout !== 32'd10) begin
            failures++;
            $display("FAIL avg_count: got cnt=%0d dout=%0d want 2/10", fifo_count, dout);
        end
        drive(0, 0, 1, 0);
        checks++;
        if (dout !== 32'hFFFF_FFFD || fifo_count !== 4'd1) begin
            failures++;
            $display("FAIL avg_neg: got dout=%0h cnt=%0d want fffffffd/1", dout, fifo_count);
        end
    endtask

    task automatic test_gaps();
        int s[4] = '{4, 8, 12, 16};
        drive(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, s[i], 0, 0);
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    drive(0, $urandom, 0, 0);
                    checks++;
                    if (dout_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL gap_push: got v=%0b want 0 at sample %0d", dout_valid, i);
                    end
                end
            end
        end
        checks++;
        if (dout !== 32'd10 || fifo_count !== 4'd1) begin
            failures++;
            $display("FAIL gap_result: got dout=%0d cnt=%0d want 10/1", dout, fifo_count);
        end
    endtask

    task automatic test_overflow();
        drive(0, 0, 0, 1);
        for (int k = 1; k <= 9; k++)
            for (int j = 0; j < D; j++) drive(1, k, 0, 0);
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%0b want 8/1", fifo_count, overflow);
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (dout !== 32'(k) || dout_valid !== 1'b1) begin
                failures++;
                $display("FAIL ovf_drain: got dout=%0d v=%0b want %0d/1", dout, dout_valid, k);
            end
            drive(0, 0, 1, 0);
        end
        checks++;
        if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_after: got v=%0b ovf=%0b want 0/1", dout_valid, overflow);
        end
    endtask

    task automatic test_full_simul();
        drive(0, 0, 0, 1);
        for (int k = 1; k <= 8; k++)
            for (int j = 0; j < D; j++) drive(1, k * 3, 0, 0);
        for (int j = 0; j < D; j++) drive(1, 27, (j == D - 1), 0);
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0 || dout !== 32'd6) begin
            failures++;
            $display("FAIL full_simul: got cnt=%0d ovf=%0b dout=%0d want 8/0/6",
                     fifo_count, overflow, dout);
        end
        for (int k = 2; k <= 9; k++) begin
            checks++;
            if (dout !== 32'(k * 3)) begin
                failures++;
                $display("FAIL full_drain: got dout=%0d want %0d", dout, k * 3);
            end
            drive(0, 0, 1, 0);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 1);
        drive(1, 1000, 0, 0); drive(1, 1000, 0, 0);
        drive(1, $urandom, 0, 1);
        for (int j = 0; j < D; j++) drive(1, 100, 0, 0);
        checks++;
        if (fifo_count !== 4'd1 || dout !== 32'd100) begin
            failures++;
            $display("FAIL reset_mid: got cnt=%0d dout=%0d want 1/100", fifo_count, dout);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] exp_d;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d = 32'h8000_0000 | $urandom_range(0, 3);
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) == 0, $urandom_range(0, 199) == 0);
            exp_d = (mq.size() > 0) ? mq[0] : 32'd0;
            checks++;
            if (dout !== exp_d || dout_valid !== (mq.size() > 0) ||
                fifo_count !== 4'(mq.size()) || overflow !== movf) begin
                failures++;
                $display("FAIL random[%0d]: got dout=%0h v=%0b cnt=%0d ovf=%0b want %0h/%0b/%0d/%0b",
                         i, dout, dout_valid, fifo_count, overflow,
                         exp_d, mq.size() > 0, mq.size(), movf);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_average();
        test_gaps();
        test_overflow();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
